// File: rtl/decode_output_queue_if.sv
// Decode/dispatch handshake bundle carrying one decoded instruction per lane.
interface pip_decode_interface;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic        rd_we;

    modport master (output valid, pc, insn, rd, rd_we, input ready);
    modport slave  (input valid, pc, insn, rd, rd_we, output ready);
endinterface

// File: rtl/decode_output_queue.sv
// Two-lane program-ordered decode output queue: alternating bank FIFOs steered by a 1-bit write pointer.
// Optional same-cycle bypass of an empty bank when DECODE_QUEUE_BYPASS_EN is defined.
module decode_output_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               flush_i,
    pip_decode_interface.slave  dec_sif0,
    pip_decode_interface.slave  dec_sif1,
    pip_decode_interface.master disp_mif0,
    pip_decode_interface.master disp_mif1
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = 70;

    typedef logic [PW-1:0] payload_t;

    logic          wptr;
    logic [CW-1:0] bank_cnt  [2];
    logic [CW-1:0] bank_rptr [2];
    logic [CW-1:0] bank_wptr [2];
    payload_t      mem       [2][DEPTH];

    payload_t in_data   [2];
    payload_t push_data [2];
    payload_t head_data [2];
    payload_t out_data  [2];
    logic [1:0] full, empty, push, out_valid, out_ready, byp_take, wr_en, rd_en;
    logic rdy0, rdy1, acc0, acc1;

    always_comb begin
        in_data[0] = {dec_sif0.pc, dec_sif0.insn, dec_sif0.rd, dec_sif0.rd_we};
        in_data[1] = {dec_sif1.pc, dec_sif1.insn, dec_sif1.rd, dec_sif1.rd_we};
        out_ready  = {disp_mif1.ready, disp_mif0.ready};
        full       = '0;
        empty      = '0;
        for (int unsigned b = 0; b < 2; b++) begin
            full[b]      = (bank_cnt[b] == CW'(DEPTH));
            empty[b]     = (bank_cnt[b] == '0);
            head_data[b] = mem[b][bank_rptr[b][AW-1:0]];
        end
    end

    // Younger lane is only accepted alongside the older one, so program order holds.
    always_comb begin
        rdy0         = ~full[wptr];
        rdy1         = rdy0 & ~full[~wptr];
        acc0         = dec_sif0.valid & rdy0;
        acc1         = dec_sif1.valid & dec_sif0.valid & rdy1;
        push[0]      = wptr ? acc1 : acc0;
        push[1]      = wptr ? acc0 : acc1;
        push_data[0] = wptr ? in_data[1] : in_data[0];
        push_data[1] = wptr ? in_data[0] : in_data[1];
    end

    always_comb begin
        out_valid = '0;
        byp_take  = '0;
        for (int unsigned b = 0; b < 2; b++) begin
`ifdef DECODE_QUEUE_BYPASS_EN
            out_valid[b] = ~empty[b] | (push[b] & ~flush_i);
            out_data[b]  = empty[b] ? push_data[b] : head_data[b];
            byp_take[b]  = empty[b] & push[b] & out_ready[b] & ~flush_i;
`else
            out_valid[b] = ~empty[b];
            out_data[b]  = head_data[b];
`endif
        end
    end

    always_comb begin
        wr_en = push & ~byp_take & {2{~flush_i}};
        rd_en = out_valid & out_ready & ~empty & {2{~flush_i}};
    end

    always_comb begin
        dec_sif0.ready  = rdy0;
        dec_sif1.ready  = rdy1;
        disp_mif0.valid = out_valid[0];
        disp_mif1.valid = out_valid[1];
        {disp_mif0.pc, disp_mif0.insn, disp_mif0.rd, disp_mif0.rd_we} = out_data[0];
        {disp_mif1.pc, disp_mif1.insn, disp_mif1.rd, disp_mif1.rd_we} = out_data[1];
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wptr <= 1'b0;
            for (int unsigned b = 0; b < 2; b++) begin
                bank_cnt[b]  <= '0;
                bank_rptr[b] <= '0;
                bank_wptr[b] <= '0;
            end
        end else if (flush_i) begin
            wptr <= 1'b0;
            for (int unsigned b = 0; b < 2; b++) begin
                bank_cnt[b]  <= '0;
                bank_rptr[b] <= '0;
                bank_wptr[b] <= '0;
            end
        end else begin
            wptr <= wptr ^ acc0 ^ acc1;
            for (int unsigned b = 0; b < 2; b++) begin
                if (wr_en[b]) bank_wptr[b] <= bank_wptr[b] + CW'(1);
                if (rd_en[b]) bank_rptr[b] <= bank_rptr[b] + CW'(1);
                bank_cnt[b] <= bank_cnt[b] + CW'(wr_en[b]) - CW'(rd_en[b]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < 2; b++) begin
            if (wr_en[b]) mem[b][bank_wptr[b][AW-1:0]] <= push_data[b];
        end
    end

    a_younger_needs_older: assert property (
        @(posedge clk_i) disable iff (arst_i) dec_sif1.valid |-> dec_sif0.valid);

endmodule

// File: tb/tb_decode_output_queue.sv
// Directed bench for decode_output_queue; covers the bypass variant when DECODE_QUEUE_BYPASS_EN is defined.
module tb_decode_output_queue;
    logic clk_i   = 1'b0;
    logic arst_i  = 1'b1;
    logic flush_i = 1'b0;

    pip_decode_interface dec_if0 ();
    pip_decode_interface dec_if1 ();
    pip_decode_interface disp_if0 ();
    pip_decode_interface disp_if1 ();

    decode_output_queue #(.DEPTH(4)) dut (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .flush_i   (flush_i),
        .dec_sif0  (dec_if0),
        .dec_sif1  (dec_if1),
        .disp_mif0 (disp_if0),
        .disp_mif1 (disp_if1)
    );

    always #5 clk_i = ~clk_i;

    int unsigned vecs = 0;
    int unsigned errs = 0;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        dec_if0.valid  = 1'b0;
        dec_if1.valid  = 1'b0;
        disp_if0.ready = 1'b0;
        disp_if1.ready = 1'b0;
    endtask

    task automatic push1(input logic [31:0] pc);
        dec_if0.valid = 1'b1;
        dec_if0.pc    = pc;
        dec_if0.insn  = pc ^ 32'hA5A5_0000;
        dec_if0.rd    = pc[6:2];
        dec_if0.rd_we = 1'b1;
        dec_if1.valid = 1'b0;
    endtask

    task automatic push2(input logic [31:0] pc0, input logic [31:0] pc1);
        push1(pc0);
        dec_if1.valid = 1'b1;
        dec_if1.pc    = pc1;
        dec_if1.insn  = pc1 ^ 32'hA5A5_0000;
        dec_if1.rd    = pc1[6:2];
        dec_if1.rd_we = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        dec_if0.pc = '0; dec_if0.insn = '0; dec_if0.rd = '0; dec_if0.rd_we = 1'b0;
        dec_if1.pc = '0; dec_if1.insn = '0; dec_if1.rd = '0; dec_if1.rd_we = 1'b0;
        arst_i = 1'b1;
        step();
        vecs++;
        if ({disp_if0.valid, disp_if1.valid, dec_if0.ready, dec_if1.ready} !== 4'b0011) begin
            errs++;
            $display("FAIL reset_state: got %b want 0011",
                     {disp_if0.valid, disp_if1.valid, dec_if0.ready, dec_if1.ready});
        end
        arst_i = 1'b0;
        step();
        vecs++;
        if ({disp_if0.valid, disp_if1.valid, dec_if0.ready, dec_if1.ready} !== 4'b0011) begin
            errs++;
            $display("FAIL idle_after_reset: got %b want 0011",
                     {disp_if0.valid, disp_if1.valid, dec_if0.ready, dec_if1.ready});
        end
    endtask

    task automatic test_pair();
        push2(32'h100, 32'h104);
        #1;
        vecs++;
        if ({dec_if0.ready, dec_if1.ready} !== 2'b11) begin
            errs++;
            $display("FAIL pair_ready: got %b want 11", {dec_if0.ready, dec_if1.ready});
        end
        step();
        idle();
        #1;
        vecs++;
        if ({disp_if0.valid, disp_if1.valid, disp_if0.pc, disp_if1.pc} !== {2'b11, 32'h100, 32'h104}) begin
            errs++;
            $display("FAIL pair_heads: got v=%b pc0=%h pc1=%h want v=11 pc0=00000100 pc1=00000104",
                     {disp_if0.valid, disp_if1.valid}, disp_if0.pc, disp_if1.pc);
        end
        vecs++;
        if ({disp_if0.insn, disp_if0.rd_we, disp_if1.rd_we} !== {32'hA5A5_0100, 2'b10}) begin
            errs++;
            $display("FAIL pair_payload: got insn0=%h we=%b want insn0=a5a50100 we=10",
                     disp_if0.insn, {disp_if0.rd_we, disp_if1.rd_we});
        end
        disp_if0.ready = 1'b1;
        disp_if1.ready = 1'b1;
        step();
        idle();
        #1;
        vecs++;
        if ({disp_if0.valid, disp_if1.valid} !== 2'b00) begin
            errs++;
            $display("FAIL pair_drain: got %b want 00", {disp_if0.valid, disp_if1.valid});
        end
    endtask

    task automatic test_in_order();
        logic [31:0] exp_pc [3];
        logic [31:0] got_pc;
        logic        got_v;
        logic        rp;
        exp_pc[0] = 32'h200; exp_pc[1] = 32'h204; exp_pc[2] = 32'h208;
        for (int i = 0; i < 3; i++) begin
            push1(exp_pc[i]);
            step();
        end
        idle();
        rp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            got_v  = rp ? disp_if1.valid : disp_if0.valid;
            got_pc = rp ? disp_if1.pc : disp_if0.pc;
            vecs++;
            if ({got_v, got_pc} !== {1'b1, exp_pc[i]}) begin
                errs++;
                $display("FAIL in_order_%0d: lane%0d got v=%b pc=%h want v=1 pc=%h",
                         i, rp, got_v, got_pc, exp_pc[i]);
            end
            if (rp) disp_if1.ready = 1'b1;
            else    disp_if0.ready = 1'b1;
            step();
            idle();
            rp = ~rp;
        end
        #1;
        vecs++;
        if ({disp_if0.valid, disp_if1.valid} !== 2'b00) begin
            errs++;
            $display("FAIL in_order_drain: got %b want 00", {disp_if0.valid, disp_if1.valid});
        end
    endtask

    task automatic test_full();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            push1(32'h400 + 32'(4 * i));
            step();
        end
        idle();
        #1;
        vecs++;
        if ({dec_if0.ready, dec_if1.ready} !== 2'b10) begin
            errs++;
            $display("FAIL rdy_b0full_wptr1: got %b want 10", {dec_if0.ready, dec_if1.ready});
        end
        push1(32'h41C);
        step();
        idle();
        #1;
        vecs++;
        if ({dec_if0.ready, dec_if1.ready, disp_if0.valid, disp_if1.valid} !== 4'b0011) begin
            errs++;
            $display("FAIL rdy_both_full: got rdy=%b v=%b want rdy=00 v=11",
                     {dec_if0.ready, dec_if1.ready}, {disp_if0.valid, disp_if1.valid});
        end
        vecs++;
        if ({disp_if0.pc, disp_if1.pc} !== {32'h400, 32'h404}) begin
            errs++;
            $display("FAIL full_heads: got pc0=%h pc1=%h want 00000400 00000404", disp_if0.pc, disp_if1.pc);
        end
        // pop bank 0 while offering a push to it: full bank must refuse despite the pop
        push1(32'hBAD0);
        disp_if0.ready = 1'b1;
        #1;
        vecs++;
        if (dec_if0.ready !== 1'b0) begin
            errs++;
            $display("FAIL full_push_pop_rdy: got %b want 0", dec_if0.ready);
        end
        step();
        idle();
        #1;
        vecs++;
        if ({dec_if0.ready, dec_if1.ready, disp_if0.pc} !== {2'b10, 32'h408}) begin
            errs++;
            $display("FAIL after_pop_full: got rdy=%b pc0=%h want rdy=10 pc0=00000408",
                     {dec_if0.ready, dec_if1.ready}, disp_if0.pc);
        end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push2(32'h600 + 32'(8 * i), 32'h604 + 32'(8 * i));
            step();
        end
        idle();
        disp_if1.ready = 1'b1;
        step();
        idle();
        push2(32'h618, 32'h61C);
        step();
        idle();
        #1;
        vecs++;
        if ({dec_if0.ready, dec_if1.ready} !== 2'b00) begin
            errs++;
            $display("FAIL rdy_b0full_wptr0: got %b want 00", {dec_if0.ready, dec_if1.ready});
        end
        vecs++;
        if ({disp_if0.pc, disp_if1.pc} !== {32'h600, 32'h60C}) begin
            errs++;
            $display("FAIL uneven_heads: got pc0=%h pc1=%h want 00000600 0000060c", disp_if0.pc, disp_if1.pc);
        end
    endtask

    task automatic test_flush();
        disp_if0.ready = 1'b1;
        step();
        idle();
        flush_i = 1'b1;
        push2(32'hF00, 32'hF04);
        disp_if0.ready = 1'b1;
        disp_if1.ready = 1'b1;
        #1;
        vecs++;
        if ({dec_if0.ready, dec_if1.ready} !== 2'b11) begin
            errs++;
            $display("FAIL rdy_during_flush: got %b want 11", {dec_if0.ready, dec_if1.ready});
        end
        step();
        idle();
        flush_i = 1'b0;
        #1;
        vecs++;
        if ({disp_if0.valid, disp_if1.valid, dec_if0.ready, dec_if1.ready} !== 4'b0011) begin
            errs++;
            $display("FAIL after_flush: got %b want 0011",
                     {disp_if0.valid, disp_if1.valid, dec_if0.ready, dec_if1.ready});
        end
        push1(32'h500);
        step();
        idle();
        #1;
        vecs++;
        if ({disp_if0.valid, disp_if1.valid, disp_if0.pc} !== {2'b10, 32'h500}) begin
            errs++;
            $display("FAIL flush_wptr0: got v=%b pc0=%h want v=10 pc0=00000500",
                     {disp_if0.valid, disp_if1.valid}, disp_if0.pc);
        end
        disp_if0.ready = 1'b1;
        step();
        idle();
        #1;
        vecs++;
        if ({disp_if0.valid, disp_if1.valid} !== 2'b00) begin
            errs++;
            $display("FAIL flush_dropped: got %b want 00", {disp_if0.valid, disp_if1.valid});
        end
    endtask

    task automatic test_async_reset();
        push2(32'h700, 32'h704);
        step();
        idle();
        #1;
        vecs++;
        if ({disp_if0.valid, disp_if1.valid} !== 2'b11) begin
            errs++;
            $display("FAIL pre_reset_fill: got %b want 11", {disp_if0.valid, disp_if1.valid});
        end
        #2;
        arst_i = 1'b1;
        #1;
        vecs++;
        if ({disp_if0.valid, disp_if1.valid, dec_if0.ready, dec_if1.ready} !== 4'b0011) begin
            errs++;
            $display("FAIL async_reset: got %b want 0011",
                     {disp_if0.valid, disp_if1.valid, dec_if0.ready, dec_if1.ready});
        end
        #1;
        arst_i = 1'b0;
        step();
        push1(32'h710);
        step();
        idle();
        #1;
        vecs++;
        if ({disp_if0.valid, disp_if1.valid, disp_if0.pc} !== {2'b10, 32'h710}) begin
            errs++;
            $display("FAIL reset_wptr0: got v=%b pc0=%h want v=10 pc0=00000710",
                     {disp_if0.valid, disp_if1.valid}, disp_if0.pc);
        end
        disp_if0.ready = 1'b1;
        step();
        idle();
    endtask

    task automatic test_latency();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        push1(32'h300);
        disp_if0.ready = 1'b1;
        #1;
`ifdef DECODE_QUEUE_BYPASS_EN
        vecs++;
        if ({disp_if0.valid, disp_if0.pc} !== {1'b1, 32'h300}) begin
            errs++;
            $display("FAIL bypass_same_cycle: got v=%b pc=%h want v=1 pc=00000300", disp_if0.valid, disp_if0.pc);
        end
        step();
        idle();
        #1;
        vecs++;
        if ({disp_if0.valid, disp_if1.valid} !== 2'b00) begin
            errs++;
            $display("FAIL bypass_not_stored: got %b want 00", {disp_if0.valid, disp_if1.valid});
        end
        flush_i = 1'b1;
        push1(32'h310);
        #1;
        vecs++;
        if ({disp_if0.valid, disp_if1.valid} !== 2'b00) begin
            errs++;
            $display("FAIL bypass_flush: got %b want 00", {disp_if0.valid, disp_if1.valid});
        end
        step();
        idle();
        flush_i = 1'b0;
`else
        vecs++;
        if (disp_if0.valid !== 1'b0) begin
            errs++;
            $display("FAIL no_bypass_same_cycle: got v=%b want 0", disp_if0.valid);
        end
        step();
        idle();
        #1;
        vecs++;
        if ({disp_if0.valid, disp_if0.pc} !== {1'b1, 32'h300}) begin
            errs++;
            $display("FAIL one_cycle_latency: got v=%b pc=%h want v=1 pc=00000300", disp_if0.valid, disp_if0.pc);
        end
        disp_if0.ready = 1'b1;
        step();
        idle();
`endif
        #1;
        vecs++;
        if ({disp_if0.valid, disp_if1.valid} !== 2'b00) begin
            errs++;
            $display("FAIL latency_end_empty: got %b want 00", {disp_if0.valid, disp_if1.valid});
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_in_order();
        test_full();
        test_flush();
        test_async_reset();
        test_latency();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
